timer_mmio_bridge: RTL
======================

// Module: timer_mmio_bridge
// PURPOSE
//  Upstream adapter between the CPU native memory bus (valid/ready, byte strobes) and the timer's
//  register port (sel/wr_en/rd_en/addr[1:0], 1-cycle registered rdata). Decodes a 16-byte window,
//  sequences timer accesses, performs read-modify-write for partial stores, and conditions
//  the timer's timeout_o into a CPU interrupt line.
// PARAMETERS
//  BASE_ADDR  32'h0200_0000  byte base of 16-byte timer window (must be 16-byte aligned)
//  IRQ_LEVEL  1              1: irq_o follows registered timeout (level); 0: 1-cycle pulse per rising edge
// PORTS
//  clk         in   1   clock
//  resetn      in   1   synchronous, active-low reset
//  mem_valid   in   1   CPU request valid; held until mem_ready
//  mem_addr    in   32  CPU byte address
//  mem_wdata   in   32  CPU write data
//  mem_wstrb   in   4   byte strobes; 4'h0 = read
//  mem_ready   out  1   1-cycle completion pulse for a hit
//  mem_rdata   out  32  read data, valid while mem_ready=1 (reads); 0 on writes
//  tmr_sel     out  1   timer select strobe
//  tmr_wr_en   out  1   timer write strobe
//  tmr_rd_en   out  1   timer read strobe
//  tmr_addr    out  2   timer register index = mem_addr[3:2]
//  tmr_wdata   out  32  timer write data
//  tmr_rdata   in   32  timer read data, valid 1 cycle after tmr_sel&tmr_rd_en
//  tmr_timeout in   1   timer timeout_o
//  irq_o       out  1   interrupt to CPU
// BEHAVIOUR
//  - Reset: state IDLE; mem_ready, mem_rdata, tmr_* strobes/addr/wdata, irq_o, timeout_q all 0.
//  - All outputs registered. Hit = mem_valid & (mem_addr[31:4]==BASE_ADDR[31:4]); mem_addr[1:0] ignored.
//    Miss: no timer strobe, mem_ready stays 0 (another slave answers).
//  - FSM IDLE->{WR,RD,RMW_RD}: request sampled in IDLE at cycle T; addr/wstrb/wdata latched at T.
//    WR  (wstrb==4'hF): T+1 sel=wr_en=1, tmr_wdata=mem_wdata -> RESP; T+2 mem_ready=1.
//    RD  (wstrb==0):    T+1 sel=rd_en=1 -> CAP; T+2 capture tmr_rdata -> RESP; T+3 mem_ready=1, mem_rdata=captured.
//    RMW (partial, addr 0..2): T+1 read -> MERGE; T+2 merge: strobed bytes from wdata, others from
//        tmr_rdata -> WR; T+3 write merged word; T+4 mem_ready=1.
//    Partial write to addr 3 (STATUS, W1C): no read; unstrobed bytes forced 0; plain WR path (ready T+2).
//  - RESP: mem_ready=1 exactly one cycle, return to IDLE; new request earliest the following cycle,
//    so a still-high mem_valid in the RESP cycle is not re-accepted.
//  - Strobes (sel, wr_en, rd_en) are 1-cycle pulses; never wr_en and rd_en together; tmr_sel=0 in idle.
//  - mem_valid dropping mid-sequence: access completes to the timer anyway; mem_ready still pulses once.
//  - resetn low in any state: next edge forces IDLE, all strobes 0, no mem_ready; no partial write issued.
//  - IRQ: timeout_q <= tmr_timeout each cycle. IRQ_LEVEL=1: irq_o <= tmr_timeout (1-cycle latency).
//    IRQ_LEVEL=0: irq_o <= tmr_timeout & ~timeout_q (one pulse per 0->1 edge; held-high gives no repeat).
//  - IRQ logic independent of bus FSM; simultaneous STATUS W1C and new timeout handled by timer, bridge just follows.
// TESTING
//  - Full write 0x0200_0004 wdata=0x64 wstrb=F at T -> T+1 sel=wr_en=1 addr=1 wdata=0x64; T+2 mem_ready=1.
//  - Read 0x0200_0008 with stub tmr_rdata=0x1234 one cycle after rd_en -> mem_ready at T+3, mem_rdata=0x1234.
//  - RMW: CTRL holds 0x0000_0A05, write wdata=0x0000_0300 wstrb=4'b0010 -> timer write 0x0000_0305, ready T+4.
//  - STATUS write wstrb=4'b0001 wdata=0xFFFF_FF01 -> single write addr=3 wdata=0x0000_0001, no read strobe.
//  - Miss 0x0300_0000 held 8 cycles -> no tmr_sel, no mem_ready; resetn low at T+1 of RMW -> no write, IDLE.
//  - IRQ_LEVEL=0: tmr_timeout 0->1 held 10 cycles -> irq_o single 1-cycle pulse; IRQ_LEVEL=1 -> high 10 cycles, lag 1.

Source files
------------

// File: rtl/timer_mmio_bridge_if.sv
// Bus bundles for the timer MMIO bridge: the CPU native memory bus and the
// timer register port. master = side that issues requests.

interface mem_bus_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

interface tmr_bus_if;
    logic        tmr_sel;
    logic        tmr_wr_en;
    logic        tmr_rd_en;
    logic [1:0]  tmr_addr;
    logic [31:0] tmr_wdata;
    logic [31:0] tmr_rdata;

    modport master (output tmr_sel, tmr_wr_en, tmr_rd_en, tmr_addr, tmr_wdata,
                    input  tmr_rdata);
    modport slave  (input  tmr_sel, tmr_wr_en, tmr_rd_en, tmr_addr, tmr_wdata,
                    output tmr_rdata);
endinterface

// File: rtl/timer_mmio_bridge.sv
// CPU memory bus -> timer register port adapter. Decodes a 16-byte window,
// turns each hit into one timer access (read-modify-write for partial stores
// to registers 0..2), and conditions the timer timeout into irq_o.

module timer_mmio_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter bit          IRQ_LEVEL = 1'b1
) (
    input  logic  clk,
    input  logic  resetn,
    mem_bus_if.slave  mem,
    tmr_bus_if.master tmr,
    input  logic  tmr_timeout,
    output logic  irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_RMW_RD,
        S_MERGE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sel_q, sel_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [1:0]  taddr_q, taddr_d;
    logic [31:0] twdata_q, twdata_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout_q;
    logic        irq_q;

    logic        hit;
    logic [31:0] req_mask;
    logic [31:0] lat_mask;
    logic        unused_addr;

    // Word-granular window: the byte offset inside a word is not decoded.
    assign unused_addr = ^mem.mem_addr[1:0];
    assign hit = mem.mem_valid && (mem.mem_addr[31:4] == BASE_ADDR[31:4]);

    // Byte-lane masks for the incoming strobes and for the latched strobes.
    assign req_mask = {{8{mem.mem_wstrb[3]}}, {8{mem.mem_wstrb[2]}},
                       {8{mem.mem_wstrb[1]}}, {8{mem.mem_wstrb[0]}}};
    assign lat_mask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}},
                       {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

    // Next-state and registered-output decode for the access sequencer.
    always_comb begin
        state_d  = state_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        sel_d    = 1'b0;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        taddr_d  = taddr_q;
        twdata_d = twdata_q;
        ready_d  = 1'b0;
        rdata_d  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    wstrb_d = mem.mem_wstrb;
                    wdata_d = mem.mem_wdata;
                    taddr_d = mem.mem_addr[3:2];
                    sel_d   = 1'b1;
                    if (mem.mem_wstrb == 4'h0) begin
                        rd_d    = 1'b1;
                        state_d = S_RD;
                    end else if (mem.mem_wstrb == 4'hF) begin
                        wr_d     = 1'b1;
                        twdata_d = mem.mem_wdata;
                        state_d  = S_WR;
                    end else if (mem.mem_addr[3:2] == 2'd3) begin
                        // STATUS is W1C: unstrobed bytes must not clear anything.
                        wr_d     = 1'b1;
                        twdata_d = mem.mem_wdata & req_mask;
                        state_d  = S_WR;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_WR: begin
                ready_d = 1'b1;
                state_d = S_RESP;
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                rdata_d = tmr.tmr_rdata;
                ready_d = 1'b1;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                sel_d    = 1'b1;
                wr_d     = 1'b1;
                twdata_d = (wdata_q & lat_mask) | (tmr.tmr_rdata & ~lat_mask);
                state_d  = S_WR;
            end
            S_RESP: begin
                // One dead cycle so a still-asserted mem_valid is not re-taken.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and bus output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            taddr_q  <= 2'd0;
            twdata_q <= 32'h0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            taddr_q  <= taddr_d;
            twdata_q <= twdata_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    // Timeout conditioning: level follow or rising-edge pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            timeout_q <= tmr_timeout;
            irq_q     <= IRQ_LEVEL ? tmr_timeout : (tmr_timeout & ~timeout_q);
        end
    end

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;
    assign tmr.tmr_sel   = sel_q;
    assign tmr.tmr_wr_en = wr_q;
    assign tmr.tmr_rd_en = rd_q;
    assign tmr.tmr_addr  = taddr_q;
    assign tmr.tmr_wdata = twdata_q;
    assign irq_o         = irq_q;

endmodule
